// File: rtl/seq_detect_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detectors
// and the 7-segment displays.
package seq_detect_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [3:0] {ST[16]} state_e;

    // Entry k holds the next state from state k for one input bit value.
    typedef logic [15:0][3:0] trans_t;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            4'hF: return 8'h8E;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Longest proper prefix (length < len) that is a suffix of the first k
    // pattern bits followed by b. Pattern bit i of the prefix is pattern[len-1-i].
    function automatic int unsigned kmp_next(input logic [15:0] pattern, input int unsigned len,
                                             input int unsigned k, input logic b);
        int unsigned best;
        int unsigned p;
        logic ok;
        logic sb;
        best = 0;
        for (int unsigned j = 1; j <= k + 1; j++) begin
            if (j < len) begin
                ok = 1'b1;
                for (int unsigned m = 0; m < j; m++) begin
                    p  = k + 1 - j + m;
                    sb = (p == k) ? b : pattern[len-1-p];
                    if (sb != pattern[len-1-m]) ok = 1'b0;
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    function automatic int unsigned kmp_fail(input logic [15:0] pattern, input int unsigned len);
        int unsigned best;
        logic ok;
        best = 0;
        for (int unsigned j = 1; j < len; j++) begin
            ok = 1'b1;
            for (int unsigned m = 0; m < j; m++) begin
                if (pattern[j-1-m] != pattern[len-1-m]) ok = 1'b0;
            end
            if (ok) best = j;
        end
        return best;
    endfunction

    function automatic trans_t build_trans(input logic [15:0] pattern, input int unsigned len,
                                           input logic b, input bit overlap);
        trans_t t;
        t = '0;
        for (int unsigned k = 0; k < len; k++) begin
            if (k == len - 1 && b == pattern[0])
                t[k] = overlap ? 4'(kmp_fail(pattern, len)) : 4'd0;
            else
                t[k] = 4'(kmp_next(pattern, len, k, b));
        end
        return t;
    endfunction

endpackage

// File: rtl/seq_detect_mealy_param_seg7_hex_decoder.sv
// Active-low hex to 7-segment decoder; decimal point (bit 7) is always off.
module seg7_hex_decoder
    import seq_detect_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [7:0] seg_o
);

    assign seg_o = hex_to_seg(hex_i);

endmodule

// File: rtl/seq_detect_mealy_param.sv
// Parametrised Mealy serial-pattern detector (KMP automaton) with saturating
// match counter and 7-segment display of the current state index.
module seq_detect_mealy_param
    import seq_detect_pkg::*;
#(
    parameter int unsigned     LEN     = 4,
    parameter logic [LEN-1:0]  PATTERN = 4'b1100,
    parameter bit              OVERLAP = 1'b1,
    parameter int unsigned     CNT_W   = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic             cnt_clr,
    output logic             y,
    output logic             y_q,
    output logic [3:0]       state_idx,
    output logic [CNT_W-1:0] match_cnt,
    output logic [7:0]       st_literal
);

    if (LEN < 2 || LEN > 16) begin : g_len_chk
        $error("seq_detect_mealy_param: LEN must be in 2..16");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_cnt_chk
        $error("seq_detect_mealy_param: CNT_W must be in 1..32");
    end

    localparam trans_t           NXT0    = build_trans(16'(PATTERN), LEN, 1'b0, OVERLAP);
    localparam trans_t           NXT1    = build_trans(16'(PATTERN), LEN, 1'b1, OVERLAP);
    localparam logic [3:0]       LAST    = 4'(LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic             yq_q;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        state_d = state_q;
        y       = 1'b0;
        if (x_valid) begin
            y       = (state_q == state_e'(LAST)) && (x == PATTERN[0]);
            state_d = state_e'(x ? NXT1[state_q] : NXT0[state_q]);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST0;
            yq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            yq_q    <= y;
        end
    end

    // Clear beats a simultaneous match; the count sticks at all-ones.
    always_ff @(posedge Clock) begin
        if (Reset || cnt_clr)
            cnt_q <= '0;
        else if (y && cnt_q != '1)
            cnt_q <= cnt_q + CNT_ONE;
    end

    assign y_q       = yq_q;
    assign state_idx = state_q;
    assign match_cnt = cnt_q;

    seg7_hex_decoder u_seg (
        .hex_i (state_idx),
        .seg_o (st_literal)
    );

endmodule
